// File: rtl/complex_mult_pipe.sv
// Three-stage pipelined complex multiplier (A*B or A*conj(B)) in signed Q format,
// with optional rounding, saturation and a sticky overflow flag.
module complex_mult_pipe #(
   parameter int WIDTH       = 16,
   parameter int FIXED_POINT = 11,
   parameter int ROUND       = 0,
   parameter int SATURATE    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] In_One_Re,
   input  logic signed [WIDTH-1:0] In_One_Im,
   input  logic signed [WIDTH-1:0] In_Two_Re,
   input  logic signed [WIDTH-1:0] In_Two_Im,
   input  logic                    Conj,
   input  logic                    In_Valid,
   output logic                    In_Ready,
   output logic signed [WIDTH-1:0] Out_Re,
   output logic signed [WIDTH-1:0] Out_Im,
   output logic                    Out_Valid,
   input  logic                    Out_Ready,
   output logic                    Ovf,
   input  logic                    Clr_Ovf
);

   localparam int PW = 2*WIDTH + 1;
   localparam int FW = 2*WIDTH + 2;
   localparam logic signed [FW-1:0] RND =
      FW'((ROUND != 0) ? ((64'd1 << FIXED_POINT) >> 1) : 64'd0);

   logic                    advance;
   logic                    valid1_q, valid2_q, valid3_q;
   logic signed [WIDTH-1:0] a_q, b_q, c_q;
   logic signed [WIDTH:0]   d_q, d_d;
   logic signed [PW-1:0]    ac_q, bd_q, ad_q, bc_q;
   logic signed [PW-1:0]    ac_d, bd_d, ad_d, bc_d;
   logic signed [PW-1:0]    aX, bX, cX, dX;
   logic signed [FW-1:0]    reSum, imSum, reShift, imShift;
   logic [WIDTH:0]          reFit, imFit;
   logic signed [WIDTH-1:0] outRe_q, outIm_q;
   logic                    ovf_q, ovfSet;

   // Result fitting: MSB flags out-of-range, low bits are the clamped or wrapped value
   function automatic logic [WIDTH:0] fitResult(input logic signed [FW-1:0] v);
      logic [FW-WIDTH:0] top;
      logic              over;
      logic [WIDTH-1:0]  r;
      top  = v[FW-1:WIDTH-1];
      over = !((&top) || !(|top));
      if (over && (SATURATE != 0))
         r = v[FW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         r = v[WIDTH-1:0];
      return {over, r};
   endfunction

   assign advance   = ~valid3_q | Out_Ready;
   assign In_Ready  = advance;
   assign Out_Valid = valid3_q;
   assign Out_Re    = outRe_q;
   assign Out_Im    = outIm_q;
   assign Ovf       = ovf_q;

   // Conjugation is applied one bit wider so that negating the most negative value is exact
   always_comb begin
      d_d = {In_Two_Im[WIDTH-1], In_Two_Im};
      if (Conj)
         d_d = -{In_Two_Im[WIDTH-1], In_Two_Im};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid1_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         d_q      <= '0;
      end else if (advance) begin
         valid1_q <= In_Valid;
         a_q      <= In_One_Re;
         b_q      <= In_One_Im;
         c_q      <= In_Two_Re;
         d_q      <= d_d;
      end
   end

   always_comb begin
      aX   = {{(PW-WIDTH){a_q[WIDTH-1]}}, a_q};
      bX   = {{(PW-WIDTH){b_q[WIDTH-1]}}, b_q};
      cX   = {{(PW-WIDTH){c_q[WIDTH-1]}}, c_q};
      dX   = {{(PW-WIDTH-1){d_q[WIDTH]}}, d_q};
      ac_d = aX * cX;
      bd_d = bX * dX;
      ad_d = aX * dX;
      bc_d = bX * cX;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid2_q <= 1'b0;
         ac_q     <= '0;
         bd_q     <= '0;
         ad_q     <= '0;
         bc_q     <= '0;
      end else if (advance) begin
         valid2_q <= valid1_q;
         ac_q     <= ac_d;
         bd_q     <= bd_d;
         ad_q     <= ad_d;
         bc_q     <= bc_d;
      end
   end

   always_comb begin
      reSum   = {ac_q[PW-1], ac_q} - {bd_q[PW-1], bd_q};
      imSum   = {ad_q[PW-1], ad_q} + {bc_q[PW-1], bc_q};
      reShift = (reSum + RND) >>> FIXED_POINT;
      imShift = (imSum + RND) >>> FIXED_POINT;
      reFit   = fitResult(reShift);
      imFit   = fitResult(imShift);
      ovfSet  = advance & valid2_q & (reFit[WIDTH] | imFit[WIDTH]);
   end

   // Output data only moves for valid slots so a bubble leaves the last result visible
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid3_q <= 1'b0;
         outRe_q  <= '0;
         outIm_q  <= '0;
      end else if (advance) begin
         valid3_q <= valid2_q;
         if (valid2_q) begin
            outRe_q <= reFit[WIDTH-1:0];
            outIm_q <= imFit[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf_q <= 1'b0;
      else
         ovf_q <= ovfSet | (ovf_q & ~Clr_Ovf);
   end

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Directed bench for complex_mult_pipe: truncating, rounding and wrapping instances
// share one stimulus stream and are checked against hand-computed results.
module tb_complex_mult_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] oneRe, oneIm, twoRe, twoIm;
   logic        conj, inValid, outReady, clrOvf;

   logic        inReady, outValid, ovf;
   logic [15:0] outRe, outIm;
   logic        inReadyR, outValidR, ovfR;
   logic [15:0] outReR, outImR;
   logic        inReadyW, outValidW, ovfW;
   logic [15:0] outReW, outImW;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [15:0] a, b, c, d;
      logic        cj;
      logic [15:0] re, im, reR, imR, reW, imW;
      logic        ov;
   } vecT;

   vecT vecs[8];

   always #5 clk = ~clk;

   complex_mult_pipe dut (
      .clk(clk), .rst(rst),
      .In_One_Re(oneRe), .In_One_Im(oneIm), .In_Two_Re(twoRe), .In_Two_Im(twoIm),
      .Conj(conj), .In_Valid(inValid), .In_Ready(inReady),
      .Out_Re(outRe), .Out_Im(outIm), .Out_Valid(outValid), .Out_Ready(outReady),
      .Ovf(ovf), .Clr_Ovf(clrOvf)
   );

   complex_mult_pipe #(.ROUND(1)) dutR (
      .clk(clk), .rst(rst),
      .In_One_Re(oneRe), .In_One_Im(oneIm), .In_Two_Re(twoRe), .In_Two_Im(twoIm),
      .Conj(conj), .In_Valid(inValid), .In_Ready(inReadyR),
      .Out_Re(outReR), .Out_Im(outImR), .Out_Valid(outValidR), .Out_Ready(outReady),
      .Ovf(ovfR), .Clr_Ovf(clrOvf)
   );

   complex_mult_pipe #(.SATURATE(0)) dutW (
      .clk(clk), .rst(rst),
      .In_One_Re(oneRe), .In_One_Im(oneIm), .In_Two_Re(twoRe), .In_Two_Im(twoIm),
      .Conj(conj), .In_Valid(inValid), .In_Ready(inReadyW),
      .Out_Re(outReW), .Out_Im(outImW), .Out_Valid(outValidW), .Out_Ready(outReady),
      .Ovf(ovfW), .Clr_Ovf(clrOvf)
   );

   task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
      end
   endtask

   // One isolated sample: checks latency, all three flavours of result, then clears Ovf
   task automatic applyStimulus(input vecT v, input int idx);
      oneRe   = v.a;
      oneIm   = v.b;
      twoRe   = v.c;
      twoIm   = v.d;
      conj    = v.cj;
      inValid = 1'b1;
      checkOutput($sformatf("v%0d inReady", idx), {31'd0, inReady}, 32'd1);
      @(posedge clk); #1;
      inValid = 1'b0;
      checkOutput($sformatf("v%0d valid after 1", idx), {31'd0, outValid}, 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d valid after 2", idx), {31'd0, outValid}, 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d valid after 3", idx), {31'd0, outValid}, 32'd1);
      checkOutput($sformatf("v%0d re", idx), {16'd0, outRe}, {16'd0, v.re});
      checkOutput($sformatf("v%0d im", idx), {16'd0, outIm}, {16'd0, v.im});
      checkOutput($sformatf("v%0d round re", idx), {16'd0, outReR}, {16'd0, v.reR});
      checkOutput($sformatf("v%0d round im", idx), {16'd0, outImR}, {16'd0, v.imR});
      checkOutput($sformatf("v%0d wrap re", idx), {16'd0, outReW}, {16'd0, v.reW});
      checkOutput($sformatf("v%0d wrap im", idx), {16'd0, outImW}, {16'd0, v.imW});
      checkOutput($sformatf("v%0d ovf", idx), {31'd0, ovf}, {31'd0, v.ov});
      checkOutput($sformatf("v%0d ovf wrap", idx), {31'd0, ovfW}, {31'd0, v.ov});
      checkOutput($sformatf("v%0d ovf round", idx), {31'd0, ovfR}, {31'd0, v.ov});
      clrOvf = 1'b1;
      @(posedge clk); #1;
      clrOvf = 1'b0;
      checkOutput($sformatf("v%0d ovf cleared", idx), {31'd0, ovf}, 32'd0);
   endtask

   initial begin
      int sent;
      int got;
      logic seen;

      vecs[0] = '{16'h0764, 16'hFCF0, 16'h05A8, 16'hFA58, 1'b0,
                  16'h030F, 16'hF89B, 16'h030F, 16'hF89C, 16'h030F, 16'hF89B, 1'b0};
      vecs[1] = '{16'h0764, 16'hFCF0, 16'h05A8, 16'hFA58, 1'b1,
                  16'h0764, 16'h030F, 16'h0764, 16'h030F, 16'h0764, 16'h030F, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0,
                  16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'hFFC0, 1'b1};
      vecs[3] = '{16'h0800, 16'h0400, 16'h0800, 16'h0800, 1'b0,
                  16'h0400, 16'h0C00, 16'h0400, 16'h0C00, 16'h0400, 16'h0C00, 1'b0};
      vecs[4] = '{16'h8000, 16'h0000, 16'h0000, 16'h8000, 1'b1,
                  16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 1'b1};
      vecs[5] = '{16'h8000, 16'h0000, 16'h0000, 16'h8000, 1'b0,
                  16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 1'b1};
      vecs[6] = '{16'h0001, 16'h0000, 16'h0400, 16'h0000, 1'b0,
                  16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      vecs[7] = '{16'hFFFF, 16'h0000, 16'h0400, 16'h0000, 1'b0,
                  16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0};

      oneRe = '0; oneIm = '0; twoRe = '0; twoIm = '0;
      conj = 1'b0; inValid = 1'b0; outReady = 1'b1; clrOvf = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset valid", {31'd0, outValid}, 32'd0);
      checkOutput("reset re", {16'd0, outRe}, 32'd0);
      checkOutput("reset im", {16'd0, outIm}, 32'd0);
      checkOutput("reset ovf", {31'd0, ovf}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("ready after reset", {31'd0, inReady}, 32'd1);

      for (int i = 0; i < 8; i++)
         applyStimulus(vecs[i], i);

      // Overflow landing in the same cycle as a clear must stay set
      oneRe = 16'h7FFF; oneIm = 16'h7FFF; twoRe = 16'h7FFF; twoIm = 16'h7FFF;
      conj = 1'b0; inValid = 1'b1; clrOvf = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("set beats clear", {31'd0, ovf}, 32'd1);
      @(posedge clk); #1;
      checkOutput("clear after set", {31'd0, ovf}, 32'd0);
      clrOvf = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Five-sample stream with the consumer stalled in cycles 4..6
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         outReady = !(cyc >= 4 && cyc <= 6);
         if (sent < 5) begin
            oneRe   = 16'((sent + 1) * 16'h0800);
            oneIm   = 16'h0000;
            twoRe   = 16'h0800;
            twoIm   = 16'h0400;
            conj    = 1'b0;
            inValid = 1'b1;
         end else begin
            inValid = 1'b0;
         end
         @(negedge clk);
         if (cyc >= 4 && cyc <= 6) begin
            checkOutput($sformatf("stall c%0d inReady", cyc), {31'd0, inReady}, 32'd0);
            checkOutput($sformatf("stall c%0d valid", cyc), {31'd0, outValid}, 32'd1);
            checkOutput($sformatf("stall c%0d re", cyc), {16'd0, outRe}, 32'h1000);
            checkOutput($sformatf("stall c%0d im", cyc), {16'd0, outIm}, 32'h0800);
         end
         if (inValid && inReady)
            sent++;
         if (outValid && outReady) begin
            if (got < 5) begin
               checkOutput($sformatf("stream %0d re", got), {16'd0, outRe}, 32'((got + 1) * 32'h0800));
               checkOutput($sformatf("stream %0d im", got), {16'd0, outIm}, 32'((got + 1) * 32'h0400));
            end
            got++;
         end
         @(posedge clk); #1;
      end
      checkOutput("stream sent", 32'(sent), 32'd5);
      checkOutput("stream received", 32'(got), 32'd5);

      // Reset with two samples in flight
      outReady = 1'b1;
      oneRe = vecs[0].a; oneIm = vecs[0].b; twoRe = vecs[0].c; twoIm = vecs[0].d;
      conj = 1'b0; inValid = 1'b1;
      @(posedge clk); #1;
      oneRe = vecs[3].a; oneIm = vecs[3].b; twoRe = vecs[3].c; twoIm = vecs[3].d;
      @(posedge clk); #1;
      inValid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("mid reset valid", {31'd0, outValid}, 32'd0);
      checkOutput("mid reset re", {16'd0, outRe}, 32'd0);
      checkOutput("mid reset im", {16'd0, outIm}, 32'd0);
      checkOutput("mid reset ovf", {31'd0, ovf}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("ready after mid reset", {31'd0, inReady}, 32'd1);
      seen = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         if (outValid)
            seen = 1'b1;
      end
      checkOutput("no output after reset", {31'd0, seen}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/complex_mult_pipe.md
COMPLEX_MULT_PIPE -- requirements
Module: complex_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning signed two's-complement width of every real/imaginary operand and result.
REQ-002 SHALL have parameter FIXED_POINT, default 11, meaning fractional bits of operands and results (same Q format in and out).
REQ-003 SHALL have parameter ROUND, default 0, meaning 0 = truncate (floor), 1 = round-half-up before the FIXED_POINT shift.
REQ-004 SHALL have parameter SATURATE, default 1, meaning 1 = clamp results to WIDTH range, 0 = wrap (keep low WIDTH bits).
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: In_One_Re, In_One_Im, In_Two_Re, In_Two_Im  in  WIDTH each  signed operand A = One, B = Two.
REQ-007 SHALL have ports: Conj  in  1  1 = compute A*conj(B), sampled with the operands; In_Valid  in  1; In_Ready  out  1.
REQ-008 SHALL have ports: Out_Re, Out_Im  out  WIDTH each  signed result; Out_Valid  out  1; Out_Ready  in  1.
REQ-009 SHALL have ports: Ovf  out  1  sticky overflow flag; Clr_Ovf  in  1  synchronous clear of Ovf.

Function
REQ-010 SHALL be a 3-stage pipeline: S1 registers operands (Conj applied), S2 registers the four products, S3 registers the rounded/shifted/saturated result.
REQ-011 SHALL accept a sample on a rising clk edge where In_Valid=1 and In_Ready=1.
REQ-012 SHALL present the result of an accepted sample with Out_Valid=1 exactly 3 cycles after acceptance when no stall occurs.
REQ-013 SHALL define advance = ~Out_Valid | Out_Ready, drive In_Ready = advance combinationally, and move all stages only when advance=1 (global stall).
REQ-014 SHALL carry a valid bit per stage; bubbles propagate as invalid slots, and invalid slots never update Ovf.
REQ-015 SHALL hold Out_Re, Out_Im and Out_Valid stable while Out_Valid=1 and Out_Ready=0.
REQ-016 SHALL hold Out_Re/Out_Im at their last value when Out_Valid=0.
REQ-017 SHALL, when Conj=1, negate In_Two_Im at WIDTH+1 bits so that negation of -2^(WIDTH-1) is exact.
REQ-018 SHALL compute Re = ac - bd and Im = ad + bc at full precision (2*WIDTH+2 bits), where a,b = One Re/Im and c,d = Two Re/Im after Conj.
REQ-019 SHALL, with ROUND=1, add 2^(FIXED_POINT-1) before the arithmetic right shift by FIXED_POINT; with ROUND=0, shift only.
REQ-020 SHALL, with SATURATE=1, clamp each shifted component to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; with SATURATE=0, keep the low WIDTH bits.
REQ-021 SHALL set Ovf on the S3 update of any valid result whose shifted Re or Im exceeds the WIDTH range, for either SATURATE setting.
REQ-022 SHALL clear Ovf when Clr_Ovf=1, except that a set in the same cycle wins.
REQ-023 SHALL process back-to-back samples at one result per cycle while Out_Ready=1.

Reset
REQ-024 SHALL, while rst=1, asynchronously clear all stage valid bits, Out_Valid, Out_Re, Out_Im and Ovf to 0.
REQ-025 SHALL discard in-flight samples on reset mid-operation, with no result emerging after rst deasserts.
REQ-026 SHALL drive In_Ready=1 from the first edge after reset, because the pipeline is empty.

Verification
REQ-027 SHALL pass, with ROUND=0: One=0x0764+0xFCF0i, Two=0x05A8+0xFA58i, Conj=0 -> 3 cycles later Out_Re=0x030F, Out_Im=0xF89B, Ovf=0.
REQ-028 SHALL pass, with ROUND=1, the same operands -> Out_Re=0x030F, Out_Im=0xF89C.
REQ-029 SHALL pass, with ROUND=0, the same operands and Conj=1 -> Out_Re=0x0764, Out_Im=0x030F.
REQ-030 SHALL pass, with SATURATE=1: One=Two=0x7FFF+0x7FFFi -> Out_Re=0x0000, Out_Im=0x7FFF, Ovf=1; then Clr_Ovf pulse -> Ovf=0.
REQ-031 SHALL pass: stream 5 samples with Out_Ready held 0 for cycles 4-6 -> In_Ready low during stall, outputs held, all 5 results in order with none lost or duplicated.
REQ-032 SHALL pass: assert rst while 2 samples are in flight -> Out_Valid=0, Out_Re=Out_Im=0 immediately, and no output after release.
